// File: rtl/peak_event_extractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_event_extractor_pkg
// Description : Shared types and default constants for the peak event
//               extractor: FSM state encoding, event record layout and
//               the record-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package peak_event_extractor_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TS_WIDTH   = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int CNT_WIDTH      = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // Event record at the default widths. The top declares the same layout
    // with its own parameter widths.
    typedef struct packed {
        logic [DEF_TS_WIDTH-1:0]          start_ts;
        logic [CNT_WIDTH-1:0]             width;
        logic signed [DEF_DATA_WIDTH-1:0] max_amp;
        logic [CNT_WIDTH-1:0]             max_offset;
    } event_t;

    function automatic int rec_width(input int dw, input int tsw);
        return tsw + (2 * CNT_WIDTH) + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : First-word-fall-through record queue. The head is visible on
//               data_o whenever valid_o is high; pop_i consumes it. A push to
//               a full queue is accepted only when a pop happens in the same
//               cycle.
// Ports       : clk, rst (sync, active-high), push_i/data_i (write side),
//               pop_i/data_o/valid_o (read side), full_o (status)
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo #(
    parameter int REC_WIDTH = 64,
    parameter int DEPTH     = 8     // power of two, >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [REC_WIDTH-1:0] data_i,
    input  logic                 pop_i,
    output logic [REC_WIDTH-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o
);

    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [REC_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign valid_o   = (count_q != '0);
    assign full_o    = (count_q == C_FULL);
    assign w_do_pop  = pop_i && valid_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_do_push && !w_do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!w_do_push && w_do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage is not reset: entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/peak_event_extractor.sv
`default_nettype none
// ============================================================================
// Module      : peak_event_extractor
// Description : Groups qualified peak samples into events (bridging up to
//               cfg_gap non-peak samples), tracks start time, width and the
//               largest excess over the mean, filters short events and queues
//               the survivors for a ready/valid consumer.
// Ports       : clk, rst (sync, active-high)
//               valid_in, peak_in, sample_in, mean_in  - upstream detector
//               cfg_min_width, cfg_gap                 - event shaping
//               evt_ready / evt_valid, evt_*           - event output queue
//               drop_cnt (saturating), busy (FSM not IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module peak_event_extractor
    import peak_event_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         peak_in,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic signed [DATA_WIDTH-1:0] mean_in,
    input  logic [7:0]                   cfg_min_width,
    input  logic [7:0]                   cfg_gap,
    input  logic                         evt_ready,
    output logic                         evt_valid,
    output logic [TS_WIDTH-1:0]          evt_start_ts,
    output logic [15:0]                  evt_width,
    output logic signed [DATA_WIDTH-1:0] evt_max_amp,
    output logic [15:0]                  evt_max_offset,
    output logic [15:0]                  drop_cnt,
    output logic                         busy
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]          start_ts;
        logic [CNT_WIDTH-1:0]         width;
        logic signed [DATA_WIDTH-1:0] max_amp;
        logic [CNT_WIDTH-1:0]         max_offset;
    } evt_rec_t;

    localparam int REC_W = rec_width(DATA_WIDTH, TS_WIDTH);
    localparam logic signed [DATA_WIDTH-1:0] AMP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] AMP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                       state_q, state_d;
    logic [TS_WIDTH-1:0]          ts_q;
    logic [TS_WIDTH-1:0]          start_ts_q;
    logic [15:0]                  width_q;
    logic [15:0]                  peak_cnt_q;
    logic [15:0]                  max_off_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [7:0]                   gap_cnt_q;
    logic [7:0]                   min_width_q;
    logic [7:0]                   gap_cfg_q;
    evt_rec_t                     rec_q;
    logic                         rec_vld_q;
    logic [15:0]                  drop_cnt_q;

    logic signed [DATA_WIDTH:0]   w_diff;
    logic signed [DATA_WIDTH-1:0] w_excess;
    logic [16:0]                  w_ext_width;
    logic [15:0]                  w_ext_off;
    logic [7:0]                   w_gap_term;
    logic                         w_start, w_extend, w_close, w_gap_start, w_gap_inc;
    evt_rec_t                     w_head;
    logic                         w_fifo_valid, w_fifo_full, w_pop;

    // Excess at one extra bit, then clamp into the signed output range.
    always_comb begin
        w_diff = {sample_in[DATA_WIDTH-1], sample_in} - {mean_in[DATA_WIDTH-1], mean_in};
        if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1])
            w_excess = w_diff[DATA_WIDTH] ? AMP_MIN : AMP_MAX;
        else
            w_excess = w_diff[DATA_WIDTH-1:0];
    end

    // A peak after a gap absorbs the bridged samples into the width; its
    // offset from the event start is the width before it is counted.
    assign w_gap_term  = (state_q == ST_GAP) ? gap_cnt_q : 8'd0;
    assign w_ext_width = {1'b0, width_q} + {9'd0, w_gap_term} + 17'd1;
    assign w_ext_off   = width_q + {8'd0, w_gap_term};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state and datapath strobes ----------------
    always_comb begin
        state_d     = state_q;
        w_start     = 1'b0;
        w_extend    = 1'b0;
        w_close     = 1'b0;
        w_gap_start = 1'b0;
        w_gap_inc   = 1'b0;
        if (valid_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (peak_in) begin
                        w_start = 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE, ST_GAP: begin
                    if (peak_in) begin
                        state_d = ST_ACTIVE;
                        // Width overflow: close at the current width and
                        // treat this peak as the first of a new event.
                        if (w_ext_width[16]) begin
                            w_close = 1'b1;
                            w_start = 1'b1;
                        end else begin
                            w_extend = 1'b1;
                        end
                    end else if (state_q == ST_ACTIVE) begin
                        if (gap_cfg_q == 8'd0) begin
                            w_close = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            w_gap_start = 1'b1;
                            state_d     = ST_GAP;
                        end
                    end else if (gap_cnt_q >= gap_cfg_q) begin
                        w_close = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        w_gap_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // ---------------- Event datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            start_ts_q  <= '0;
            width_q     <= '0;
            peak_cnt_q  <= '0;
            max_q       <= '0;
            max_off_q   <= '0;
            gap_cnt_q   <= '0;
            min_width_q <= '0;
            gap_cfg_q   <= '0;
            rec_q       <= '0;
            rec_vld_q   <= 1'b0;
        end else begin
            if (valid_in) ts_q <= ts_q + TS_WIDTH'(1);

            if (state_q == ST_IDLE) begin
                min_width_q <= cfg_min_width;
                gap_cfg_q   <= cfg_gap;
            end

            if (w_start) begin
                start_ts_q <= ts_q;
                width_q    <= 16'd1;
                peak_cnt_q <= 16'd1;
                max_q      <= w_excess;
                max_off_q  <= 16'd0;
            end else if (w_extend) begin
                width_q    <= w_ext_width[15:0];
                peak_cnt_q <= peak_cnt_q + 16'd1;
                if (w_excess > max_q) begin
                    max_q     <= w_excess;
                    max_off_q <= w_ext_off;
                end
            end

            if (w_gap_start)    gap_cnt_q <= 8'd1;
            else if (w_gap_inc) gap_cnt_q <= gap_cnt_q + 8'd1;

            // peak_cnt is never 0, so a zero minimum behaves as one.
            rec_vld_q <= w_close && (peak_cnt_q >= {8'd0, min_width_q});
            if (w_close) begin
                rec_q.start_ts   <= start_ts_q;
                rec_q.width      <= width_q;
                rec_q.max_amp    <= max_q;
                rec_q.max_offset <= max_off_q;
            end
        end
    end

    // ---------------- Output queue ----------------
    assign w_pop = w_fifo_valid && evt_ready;

    event_fifo #(
        .REC_WIDTH (REC_W),
        .DEPTH     (FIFO_DEPTH)
    ) u_event_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rec_vld_q),
        .data_i  (rec_q),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .valid_o (w_fifo_valid),
        .full_o  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (rec_vld_q && w_fifo_full && !w_pop && (drop_cnt_q != CNT_MAX))
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    // Head fields read as zero while the queue is empty.
    assign evt_valid      = w_fifo_valid;
    assign evt_start_ts   = w_fifo_valid ? w_head.start_ts   : '0;
    assign evt_width      = w_fifo_valid ? w_head.width      : '0;
    assign evt_max_amp    = w_fifo_valid ? w_head.max_amp    : '0;
    assign evt_max_offset = w_fifo_valid ? w_head.max_offset : '0;
    assign drop_cnt       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_peak_event_extractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_event_extractor
// Description : Directed self-checking bench for peak_event_extractor with a
//               queue of expected event records compared at each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_event_extractor;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic               peak_in = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic signed [15:0] mean_in = '0;
    logic [7:0]         cfg_min_width = 8'd1;
    logic [7:0]         cfg_gap = 8'd0;
    logic               evt_ready = 1'b1;
    logic               evt_valid;
    logic [31:0]        evt_start_ts;
    logic [15:0]        evt_width;
    logic signed [15:0] evt_max_amp;
    logic [15:0]        evt_max_offset;
    logic [15:0]        drop_cnt;
    logic               busy;

    typedef struct {
        logic [31:0] ts;
        logic [15:0] w;
        logic [15:0] amp;
        logic [15:0] off;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned ts_m = 0;

    peak_event_extractor dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .peak_in        (peak_in),
        .sample_in      (sample_in),
        .mean_in        (mean_in),
        .cfg_min_width  (cfg_min_width),
        .cfg_gap        (cfg_gap),
        .evt_ready      (evt_ready),
        .evt_valid      (evt_valid),
        .evt_start_ts   (evt_start_ts),
        .evt_width      (evt_width),
        .evt_max_amp    (evt_max_amp),
        .evt_max_offset (evt_max_offset),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] ts, input logic [15:0] w,
                            input logic [15:0] amp, input logic [15:0] off);
        exp_t e;
        e.ts = ts; e.w = w; e.amp = amp; e.off = off;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic p,
                        input logic signed [15:0] s, input logic signed [15:0] m);
        valid_in = v; peak_in = p; sample_in = s; mean_in = m;
        @(posedge clk); #1;
        if (v) ts_m++;
        valid_in = 1'b0; peak_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'sd0, 16'sd0);
    endtask

    // valid_in/peak_in held high during reset: reset must win.
    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b1; peak_in = 1'b1; sample_in = 16'sd5; mean_in = 16'sd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; valid_in = 1'b0; peak_in = 1'b0;
        ts_m = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_all_events_seen", exp_q.size(), 0);
    endtask

    // Scoreboard: compare the head at every accepted handshake.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            chk("event_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_start_ts",   evt_start_ts, e.ts);
                chk("evt_width",      evt_width, e.w);
                chk("evt_max_amp",    {48'd0, evt_max_amp}, {48'd0, e.amp});
                chk("evt_max_offset", evt_max_offset, e.off);
            end
        end
    end

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_start_ts", evt_start_ts, 0);
        chk("rst_width", evt_width, 0);
        chk("rst_max_amp", {48'd0, evt_max_amp}, 0);
        chk("rst_max_offset", evt_max_offset, 0);

        // ---- peaks at ts 10..14, no gap bridging, min width 3 ----
        cfg_min_width = 8'd3; cfg_gap = 8'd0;
        idle(1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'sd0, 16'sd0);
        push_exp(32'd10, 16'd5, 16'd5, 16'd4);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(i), 16'sd0);
        chk("t1_busy_active", busy, 1);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        chk("t1_valid_after_close_edge", evt_valid, 0);
        idle(1);
        chk("t1_valid_two_edges_after", evt_valid, 1);
        drain(20);

        // ---- gap bridging: cfg_gap=2 gives one event of width 6 ----
        do_reset();
        cfg_min_width = 8'd1; cfg_gap = 8'd2;
        push_exp(32'd0, 16'd6, 16'd7, 16'd1);
        step(1'b1, 1'b1, 16'sd3, 16'sd0);
        step(1'b1, 1'b1, 16'sd7, 16'sd0);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        step(1'b1, 1'b1, 16'sd7, 16'sd0);
        step(1'b1, 1'b1, 16'sd2, 16'sd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'sd0, 16'sd0);
        chk("t2_idle_after_close", busy, 0);
        drain(20);

        // ---- same pattern, cfg_gap=1 splits into two events of width 2 ----
        do_reset();
        cfg_gap = 8'd1;
        push_exp(32'd0, 16'd2, 16'd7, 16'd1);
        push_exp(32'd4, 16'd2, 16'd7, 16'd0);
        step(1'b1, 1'b1, 16'sd3, 16'sd0);
        step(1'b1, 1'b1, 16'sd7, 16'sd0);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        step(1'b1, 1'b1, 16'sd7, 16'sd0);
        step(1'b1, 1'b1, 16'sd2, 16'sd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 16'sd0, 16'sd0);
        drain(20);

        // ---- excess 5,9,9,3 over a negative mean: first max wins ----
        cfg_gap = 8'd0;
        idle(1);
        push_exp(32'(ts_m), 16'd4, 16'd9, 16'd1);
        step(1'b1, 1'b1, -16'sd95, -16'sd100);
        step(1'b1, 1'b1, -16'sd91, -16'sd100);
        step(1'b1, 1'b1, -16'sd91, -16'sd100);
        step(1'b1, 1'b1, -16'sd97, -16'sd100);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        drain(20);

        // ---- excess saturation at both ends ----
        push_exp(32'(ts_m), 16'd1, 16'h7FFF, 16'd0);
        step(1'b1, 1'b1, 16'sd32767, -16'sd32768);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        push_exp(32'(ts_m), 16'd1, 16'h8000, 16'd0);
        step(1'b1, 1'b1, -16'sd32768, 16'sd32767);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        drain(20);

        // ---- short burst below minimum width is discarded ----
        cfg_min_width = 8'd3;
        idle(1);
        step(1'b1, 1'b1, 16'sd4, 16'sd0);
        step(1'b1, 1'b1, 16'sd4, 16'sd0);
        step(1'b1, 1'b0, 16'sd0, 16'sd0);
        idle(6);
        chk("t5_no_event", evt_valid, 0);
        chk("t5_drop_unchanged", drop_cnt, 0);

        // ---- 9 events into a depth-8 queue with the consumer stalled ----
        cfg_min_width = 8'd1;
        evt_ready = 1'b0;
        idle(1);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) push_exp(32'(ts_m), 16'd1, 16'(i + 1), 16'd0);
            step(1'b1, 1'b1, 16'(i + 1), 16'sd0);
            step(1'b1, 1'b0, 16'sd0, 16'sd0);
        end
        idle(3);
        chk("t6_drop_cnt_one", drop_cnt, 1);
        chk("t6_valid_stalled", evt_valid, 1);
        chk("t6_head_ts", evt_start_ts, exp_q[0].ts);
        idle(3);
        chk("t6_head_ts_stable", evt_start_ts, exp_q[0].ts);
        chk("t6_head_amp_stable", {48'd0, evt_max_amp}, {48'd0, exp_q[0].amp});
        evt_ready = 1'b1;
        drain(40);
        chk("t6_drop_cnt_after_drain", drop_cnt, 1);

        // ---- reset in the middle of an event ----
        step(1'b1, 1'b1, 16'sd6, 16'sd0);
        step(1'b1, 1'b1, 16'sd6, 16'sd0);
        chk("t7_busy_before_rst", busy, 1);
        rst = 1'b1; valid_in = 1'b1; peak_in = 1'b0;
        @(posedge clk); #1;
        chk("t7_busy_after_rst", busy, 0);
        chk("t7_valid_after_rst", evt_valid, 0);
        rst = 1'b0; valid_in = 1'b0;
        ts_m = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'sd0, 16'sd0);
        idle(6);
        chk("t7_no_event_after_rst", evt_valid, 0);
        chk("t7_drop_cnt_cleared", drop_cnt, 0);
        chk("t7_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/peak_event_extractor.md
PEAK_EVENT_EXTRACTOR -- requirements
Module: peak_event_extractor

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the sample/mean width (signed).
REQ-002 The block SHALL have parameter TS_WIDTH, default 32, giving the timestamp width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of 2), giving the event queue depth.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port valid_in, input, 1 bit: upstream detector output valid.
REQ-007 The block SHALL have port peak_in, input, 1 bit: upstream peak flag, qualified by valid_in.
REQ-008 The block SHALL have port sample_in, input, signed DATA_WIDTH: the raw sample aligned with peak_in.
REQ-009 The block SHALL have port mean_in, input, signed DATA_WIDTH: the upstream filtered mean aligned with peak_in.
REQ-010 The block SHALL have port cfg_min_width, input, 8 bits: the minimum peak-sample count for an event to be kept.
REQ-011 The block SHALL have port cfg_gap, input, 8 bits: the maximum number of non-peak samples bridged inside one event.
REQ-012 The block SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-013 The block SHALL have port evt_valid, output, 1 bit: the head event is available.
REQ-014 The block SHALL have port evt_start_ts, output, TS_WIDTH: the timestamp of the event's first peak sample.
REQ-015 The block SHALL have port evt_width, output, 16 bits: the sample count from first to last peak sample inclusive.
REQ-016 The block SHALL have port evt_max_amp, output, signed DATA_WIDTH: the maximum excess (sample_in - mean_in).
REQ-017 The block SHALL have port evt_max_offset, output, 16 bits: the offset of the maximum from event start.
REQ-018 The block SHALL have port drop_cnt, output, 16 bits: the number of events lost to a full FIFO, saturating.
REQ-019 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-020 ts SHALL be a TS_WIDTH counter that increments on every valid_in, wraps modulo 2^TS_WIDTH, and is tagged before increment.
REQ-021 The FSM SHALL have states IDLE, ACTIVE and GAP, and SHALL advance only on cycles with valid_in=1.
REQ-022 cfg_min_width and cfg_gap SHALL be latched only when in IDLE, so they stay stable for the whole event.
REQ-023 IDLE + peak: the FSM SHALL go to ACTIVE with start_ts=ts, width=1, peak_cnt=1, max=excess and max_off=0.
REQ-024 ACTIVE + peak: width and peak_cnt SHALL increment, and max/max_off SHALL update on strictly greater excess (the first occurrence wins ties).
REQ-025 ACTIVE + non-peak: if cfg_gap=0 the event SHALL close; otherwise the FSM SHALL go to GAP with gap_cnt=1.
REQ-026 GAP + non-peak: gap_cnt SHALL increment, and the event SHALL close when gap_cnt would exceed cfg_gap.
REQ-027 GAP + peak: the FSM SHALL return to ACTIVE with width += gap_cnt+1, then apply the peak_cnt and max update rules.
REQ-028 Trailing gap samples SHALL be excluded from evt_width.
REQ-029 Excess SHALL be computed at DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range.
REQ-030 If width would pass 0xFFFF, the event SHALL force-close at width 0xFFFF, and the same sample SHALL be handled as if arriving in IDLE.
REQ-031 On close, the event SHALL be pushed only if peak_cnt >= cfg_min_width (0 counts as 1); otherwise it SHALL be discarded silently; the FSM SHALL then return to IDLE.
REQ-032 The event record SHALL be registered at the closing edge and written to the FIFO on the next edge.
REQ-033 With an empty FIFO, evt_valid SHALL rise 2 edges after the closing sample.
REQ-034 The FIFO SHALL be first-word-fall-through; the head SHALL be popped on evt_valid && evt_ready.
REQ-035 Head fields SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-036 A push to a full FIFO SHALL be accepted if a pop occurs in the same cycle; otherwise the event SHALL be dropped and drop_cnt incremented, saturating at 0xFFFF.
REQ-037 Simultaneous push and pop on an empty FIFO SHALL be impossible; the push SHALL become the head on the next cycle.

Reset
REQ-038 On rst, the FSM SHALL go to IDLE, ts and all counters SHALL be 0, and the FIFO SHALL be emptied.
REQ-039 On rst, all outputs SHALL be 0, including evt_valid, the evt_* fields, drop_cnt and busy.
REQ-040 Reset mid-event SHALL discard the partial event with no push.
REQ-041 Reset SHALL dominate valid_in in the same cycle.

Structure
REQ-042 A shared package SHALL hold the FSM state enum, the event record struct (start_ts, width, max_amp, max_offset), and the default constants.
REQ-043 The FIFO SHALL be a sub-module named event_fifo, parameterised by record width and depth.

Verification
REQ-044 The bench SHALL drive peaks at ts 10-14 with cfg_gap=0 and cfg_min_width=3, and SHALL see one event with start_ts=10 and width=5.
REQ-045 The bench SHALL drive peaks at ts 0-1, non-peak at ts 2-3 and peaks at ts 4-5 with cfg_gap=2, and SHALL see one event with width=6; with cfg_gap=1 it SHALL see two events of width 2.
REQ-046 The bench SHALL drive excess sequence 5,9,9,3, and SHALL see evt_max_amp=9 and evt_max_offset=1.
REQ-047 The bench SHALL drive a 2-peak-sample burst with cfg_min_width=3, and SHALL see no event and drop_cnt unchanged.
REQ-048 The bench SHALL hold evt_ready=0 and generate 9 qualifying events with FIFO_DEPTH=8, and SHALL see drop_cnt=1, then 8 pops in order.
REQ-049 The bench SHALL assert rst during ACTIVE, and SHALL see busy=0 and evt_valid=0 next cycle, with no event ever emitted.
